// File: rtl/prince_session_ctrl.sv
// prince_session_ctrl
//   Upstream sequencer for the masked PRINCE round core. Accepts plaintext/key
//   shares over a valid/ready handshake, pulses the core start (which also
//   resets the round Controller), waits for the first rising edge of core done,
//   captures the ciphertext shares and offers them downstream over valid/ready.
//   A watchdog aborts a run that does not finish within TIMEOUT RUN cycles.
//
// Ports
//   clk_i          clock, all logic on posedge
//   reset_i        synchronous active-high reset
//   in_valid_i     input shares valid
//   in_ready_o     ready for a new request (IDLE only, low while in reset)
//   in_pt_i        plaintext shares, 64*SHARES bits
//   in_key_i       key shares, 128*SHARES bits
//   core_start_o   one-cycle start pulse to core / Controller reset
//   core_pt_o      registered plaintext shares to core
//   core_key_o     registered key shares to core, stable for the whole run
//   core_done_i    Controller done (level, may stay high several cycles)
//   core_ct_i      ciphertext shares from core
//   out_valid_o    captured ciphertext valid
//   out_ready_i    downstream accepts ciphertext
//   out_ct_o       captured ciphertext shares
//   busy_o         high whenever the FSM is not IDLE
//   err_o          one-cycle pulse after a watchdog timeout

module prince_session_ctrl #(
    parameter int unsigned SHARES  = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [64*SHARES-1:0]    in_pt_i,
    input  logic [128*SHARES-1:0]   in_key_i,
    output logic                    core_start_o,
    output logic [64*SHARES-1:0]    core_pt_o,
    output logic [128*SHARES-1:0]   core_key_o,
    input  logic                    core_done_i,
    input  logic [64*SHARES-1:0]    core_ct_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [64*SHARES-1:0]    out_ct_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned PtW  = 64 * SHARES;
    localparam int unsigned KeyW = 128 * SHARES;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [PtW-1:0]    pt_q, pt_d;
    logic [KeyW-1:0]   key_q, key_d;
    logic [PtW-1:0]    ct_q, ct_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        pt_d        = pt_q;
        key_d       = key_q;
        ct_d        = ct_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    pt_d    = in_pt_i;
                    key_d   = in_key_i;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                // Preset to 1 so a done level left over from a previous run is
                // not mistaken for a rising edge in the first RUN cycle.
                done_d  = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntOne;
                end
                done_d = core_done_i;
                // Capture on the first done cycle only; done beats timeout.
                if (core_done_i && !done_q) begin
                    ct_d        = core_ct_i;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pt_q        <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o   = (state_q == StIdle) && !reset_i;
    assign core_start_o = (state_q == StStart);
    assign core_pt_o    = pt_q;
    assign core_key_o   = key_q;
    assign out_valid_o  = out_valid_q;
    assign out_ct_o     = ct_q;
    assign busy_o       = (state_q != StIdle);
    assign err_o        = err_q;

endmodule
